// File: rtl/layer_input_buffer_if.sv
// Capture, parallel-read and streaming signals of layer_input_buffer.
// master drives strobes, input vector and stream_ready; slave is the buffer.
interface layer_input_buffer_if #(
    parameter int WEIGHT_NO  = 784,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1
);
    localparam int IDX_W = (WEIGHT_NO > 1) ? $clog2(WEIGHT_NO) : 1;

    logic                            first;
    logic                            done_in;
    logic [WEIGHT_NO*DATA_WIDTH-1:0] in;
    logic                            consume_done;
    logic [WEIGHT_NO*DATA_WIDTH-1:0] out;
    logic                            active_valid;
    logic [1:0]                      occupancy;
    logic                            stream_valid;
    logic                            stream_ready;
    logic [LANES*DATA_WIDTH-1:0]     stream_data;
    logic [IDX_W-1:0]                stream_idx;
    logic                            stream_last;
    logic                            overflow;

    modport master (
        output first, done_in, in, consume_done, stream_ready,
        input  out, active_valid, occupancy, stream_valid, stream_data,
               stream_idx, stream_last, overflow
    );

    modport slave (
        input  first, done_in, in, consume_done, stream_ready,
        output out, active_valid, occupancy, stream_valid, stream_data,
               stream_idx, stream_last, overflow
    );
endinterface

// File: rtl/layer_input_buffer.sv
// Ping-pong activation store: ACTIVE bank drives the parallel output and the
// LANES-wide stream, SHADOW bank holds the next vector until ACTIVE is released.

// One stream lane: picks element idx+LANE out of the active bank.
module layer_input_buffer_lane #(
    parameter int WEIGHT_NO  = 784,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 10,
    parameter int LANE       = 0
) (
    input  logic [WEIGHT_NO-1:0][DATA_WIDTH-1:0] bank,
    input  logic [IDX_W-1:0]                     idx,
    output logic [DATA_WIDTH-1:0]                elem
);
    logic [IDX_W-1:0] sel;

    assign sel  = idx + IDX_W'(LANE);
    assign elem = bank[sel];
endmodule

module layer_input_buffer #(
    parameter int WEIGHT_NO  = 784,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    layer_input_buffer_if.slave bus
);
    localparam int IDX_W = (WEIGHT_NO > 1) ? $clog2(WEIGHT_NO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WEIGHT_NO - LANES);
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES);

    typedef logic [WEIGHT_NO-1:0][DATA_WIDTH-1:0] bank_t;
    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAINED} state_t;
    typedef enum logic [1:0] {SRC_KEEP, SRC_SHADOW, SRC_IN} src_t;

    bank_t            active_q, shadow_q, in_vec;
    logic             active_valid_q, shadow_full_q, overflow_q;
    state_t           state_q;
    logic [IDX_W-1:0] idx_q;

    logic capture, rel;
    logic active_valid_n, shadow_full_n, overflow_n, shadow_load, reload;
    src_t active_src;

    assign in_vec  = bus.in;
    assign capture = bus.first | bus.done_in;
    assign rel     = bus.consume_done & active_valid_q;

    // Release is resolved first; capture then sees the post-release flags,
    // which makes the simultaneous release+capture cases fall out naturally.
    always_comb begin
        active_valid_n = active_valid_q;
        shadow_full_n  = shadow_full_q;
        overflow_n     = 1'b0;
        shadow_load    = 1'b0;
        reload         = 1'b0;
        active_src     = SRC_KEEP;
        if (rel) begin
            if (shadow_full_q) begin
                active_src    = SRC_SHADOW;
                shadow_full_n = 1'b0;
                reload        = 1'b1;
            end else begin
                active_valid_n = 1'b0;
            end
        end
        if (capture) begin
            if (!active_valid_n) begin
                active_src     = SRC_IN;
                active_valid_n = 1'b1;
                reload         = 1'b1;
            end else if (!shadow_full_n) begin
                shadow_load   = 1'b1;
                shadow_full_n = 1'b1;
            end else begin
                overflow_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q       <= '0;
            shadow_q       <= '0;
            active_valid_q <= 1'b0;
            shadow_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            case (active_src)
                SRC_SHADOW: active_q <= shadow_q;
                SRC_IN:     active_q <= in_vec;
                default:    ;
            endcase
            if (shadow_load) shadow_q <= in_vec;
            active_valid_q <= active_valid_n;
            shadow_full_q  <= shadow_full_n;
            overflow_q     <= overflow_n;
        end
    end

    // Any reload restarts the stream, even mid-vector; an empty ACTIVE idles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else if (reload) begin
            state_q <= ST_STREAM;
            idx_q   <= '0;
        end else if (!active_valid_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_STREAM: begin
                    if (bus.stream_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DRAINED;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + STEP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic [LANES-1:0][DATA_WIDTH-1:0] lane_data;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        layer_input_buffer_lane #(
            .WEIGHT_NO (WEIGHT_NO),
            .DATA_WIDTH(DATA_WIDTH),
            .IDX_W     (IDX_W),
            .LANE      (l)
        ) u_lane (
            .bank(active_q),
            .idx (idx_q),
            .elem(lane_data[l])
        );
    end

    assign bus.out          = active_q;
    assign bus.active_valid = active_valid_q;
    assign bus.occupancy    = {1'b0, active_valid_q} + {1'b0, shadow_full_q};
    assign bus.stream_valid = (state_q == ST_STREAM);
    assign bus.stream_data  = lane_data;
    assign bus.stream_idx   = idx_q;
    assign bus.stream_last  = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_layer_input_buffer.sv
// Two buffers (LANES=2 and LANES=1) share one stimulus stream and are checked
// against a queue-based model of live vectors and per-instance stream position.
module tb_layer_input_buffer;
    localparam int N = 8;
    localparam int W = 16;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    layer_input_buffer_if #(.WEIGHT_NO(N), .DATA_WIDTH(W), .LANES(2)) ifa ();
    layer_input_buffer_if #(.WEIGHT_NO(N), .DATA_WIDTH(W), .LANES(1)) ifb ();

    layer_input_buffer #(.WEIGHT_NO(N), .DATA_WIDTH(W), .LANES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    layer_input_buffer #(.WEIGHT_NO(N), .DATA_WIDTH(W), .LANES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));

    logic [N*W-1:0] o_out [2];
    logic [31:0]    o_sd  [2];
    logic [2:0]     o_idx [2];
    logic [1:0]     o_occ [2];
    logic           o_av [2], o_sv [2], o_last [2], o_ovf [2];

    assign o_out[0] = ifa.out;          assign o_out[1] = ifb.out;
    assign o_sd[0]  = ifa.stream_data;  assign o_sd[1]  = {16'h0, ifb.stream_data};
    assign o_idx[0] = ifa.stream_idx;   assign o_idx[1] = ifb.stream_idx;
    assign o_occ[0] = ifa.occupancy;    assign o_occ[1] = ifb.occupancy;
    assign o_av[0]  = ifa.active_valid; assign o_av[1]  = ifb.active_valid;
    assign o_sv[0]  = ifa.stream_valid; assign o_sv[1]  = ifb.stream_valid;
    assign o_last[0] = ifa.stream_last; assign o_last[1] = ifb.stream_last;
    assign o_ovf[0] = ifa.overflow;     assign o_ovf[1] = ifb.overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: live vectors in arrival order, plus each instance's stream position.
    vec_t q[$];
    vec_t last_out;
    bit   ovf_m;
    int   ptr [2];
    bit   drn [2];

    function automatic int lanes(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec_t seq_vec(input int base);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = W'(base + i);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = W'($urandom);
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        last_out = '0;
        ovf_m    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ptr[d] = 0;
            drn[d] = 1'b0;
        end
    endtask

    task automatic model_restart();
        for (int d = 0; d < 2; d++) begin
            ptr[d] = 0;
            drn[d] = 1'b0;
        end
    endtask

    task automatic model_step(input bit cap, input vec_t vi, input bit cons, input bit rdy);
        for (int d = 0; d < 2; d++) begin
            if (q.size() > 0 && !drn[d] && rdy) begin
                ptr[d] += lanes(d);
                if (ptr[d] == N) begin
                    drn[d] = 1'b1;
                    ptr[d] = 0;
                end
            end
        end
        ovf_m = 1'b0;
        if (cons && q.size() > 0) begin
            void'(q.pop_front());
            if (q.size() > 0) model_restart();
        end
        if (cap) begin
            if (q.size() < 2) begin
                q.push_back(vi);
                if (q.size() == 1) model_restart();
            end else begin
                ovf_m = 1'b1;
            end
        end
        if (q.size() > 0) last_out = q[0];
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            string s;
            bit    sv;
            logic [31:0] e;
            s  = (d == 0) ? "a" : "b";
            sv = (q.size() > 0) && !drn[d];
            chk({s, ".active_valid"}, 256'(o_av[d]), 256'(q.size() > 0));
            chk({s, ".occupancy"}, 256'(o_occ[d]), 256'(q.size()));
            chk({s, ".out"}, 256'(o_out[d]), 256'(last_out));
            chk({s, ".overflow"}, 256'(o_ovf[d]), 256'(ovf_m));
            chk({s, ".stream_valid"}, 256'(o_sv[d]), 256'(sv));
            if (sv) begin
                e = '0;
                for (int l = 0; l < lanes(d); l++) e[l*W +: W] = q[0][ptr[d] + l];
                chk({s, ".stream_idx"}, 256'(o_idx[d]), 256'(ptr[d]));
                chk({s, ".stream_last"}, 256'(o_last[d]), 256'(ptr[d] == N - lanes(d)));
                chk({s, ".stream_data"}, 256'(o_sd[d]), 256'(e));
            end
        end
    endtask

    task automatic drive(input bit fi, input bit di, input vec_t vi, input bit ci, input bit ri);
        ifa.first = fi; ifa.done_in = di; ifa.in = vi; ifa.consume_done = ci; ifa.stream_ready = ri;
        ifb.first = fi; ifb.done_in = di; ifb.in = vi; ifb.consume_done = ci; ifb.stream_ready = ri;
    endtask

    task automatic cycle(input bit fi, input bit di, input vec_t vi, input bit ci, input bit ri);
        drive(fi, di, vi, ci, ri);
        @(posedge clk);
        model_step(fi | di, vi, ci, ri);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit ri);
        cycle(1'b0, 1'b0, '0, 1'b0, ri);
    endtask

    // Reset must clear outputs asynchronously, before any clock edge.
    task automatic do_reset();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst.out", 256'(o_out[d]), 256'(0));
            chk("rst.active_valid", 256'(o_av[d]), 256'(0));
            chk("rst.occupancy", 256'(o_occ[d]), 256'(0));
            chk("rst.stream_valid", 256'(o_sv[d]), 256'(0));
            chk("rst.stream_idx", 256'(o_idx[d]), 256'(0));
            chk("rst.stream_last", 256'(o_last[d]), 256'(0));
            chk("rst.overflow", 256'(o_ovf[d]), 256'(0));
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v1, v2;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        do_reset();

        // Load 1..8 and stream it with ready held high
        v1 = seq_vec(1);
        v2 = seq_vec(11);
        cycle(1'b1, 1'b0, v1, 1'b0, 1'b0);
        chk("first.data_a", 256'(o_sd[0]), 256'({16'd2, 16'd1}));
        repeat (8) idle(1'b1);
        chk("drained_a", 256'(o_sv[0]), 256'(0));

        // Release, reload, then queue a second vector while streaming
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, v1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, v2, 1'b0, 1'b1);
        chk("shadow.occ", 256'(o_occ[0]), 256'(2));
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("swap.out", 256'(o_out[0]), 256'(v2));

        // Fill shadow, overflow, then simultaneous release + capture
        cycle(1'b0, 1'b1, seq_vec(21), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, seq_vec(31), 1'b0, 1'b0);
        chk("ovf.pulse", 256'(o_ovf[0]), 256'(1));
        cycle(1'b1, 1'b1, seq_vec(41), 1'b1, 1'b0);
        chk("both.no_ovf", 256'(o_ovf[0]), 256'(0));
        chk("both.out", 256'(o_out[0]), 256'(seq_vec(21)));

        // Stalls: ready 1,0,0,1 pattern
        for (int k = 0; k < 12; k++) idle(k % 4 == 0 || k % 4 == 3);

        // Active full / shadow empty + both events: incoming lands in ACTIVE
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, seq_vec(51), 1'b1, 1'b0);
        chk("rel_cap.occ", 256'(o_occ[0]), 256'(1));

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom % 10) == 0, ($urandom % 8) == 0, rand_vec(),
                  ($urandom % 9) == 0, ($urandom % 10) < 7);
        end

        // Mid-stream reset at idx 4, then a clean restart
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, v1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("mid.idx_a", 256'(o_idx[0]), 256'(4));
        do_reset();
        cycle(1'b1, 1'b0, v2, 1'b0, 1'b0);
        chk("post_rst.out", 256'(o_out[0]), 256'(v2));
        repeat (9) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_input_buffer.md
# layer_input_buffer

Double-buffered activation store at the input of each fully-connected layer. Captures a complete activation vector from the previous layer, or the first image, into a ping-pong bank pair. It presents the active vector in parallel and also streams it LANES elements per beat under valid/ready. A second vector can be captured while the current one is still in use, so consecutive layers and images overlap without losing data.

## Interface
- WEIGHT_NO, 784, elements per activation vector
- DATA_WIDTH, 16, bits per element (two's complement fixed point, passed through untouched)
- LANES, 1, elements per stream beat; WEIGHT_NO % LANES == 0 required
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- first  in  1  capture strobe for the first vector (network input)
- done_in  in  1  capture strobe from previous layer; first|done_in is one capture event
- in  in  WEIGHT_NO*DATA_WIDTH  vector sampled on a capture event
- consume_done  in  1  downstream layer has finished with the active vector
- out  out  WEIGHT_NO*DATA_WIDTH  active bank, parallel
- active_valid  out  1  active bank holds a live vector
- occupancy  out  2  live vectors held (0..2)
- stream_valid  out  1  stream beat available
- stream_ready  in  1  consumer accepts beat
- stream_data  out  LANES*DATA_WIDTH  elements idx..idx+LANES-1, element idx in low bits
- stream_idx  out  $clog2(WEIGHT_NO)  index of first element in beat
- stream_last  out  1  current beat is final beat of vector
- overflow  out  1  one-cycle pulse: capture dropped

## Operation
- Banks: ACTIVE (drives out, stream source) and SHADOW. Flags active_valid, shadow_full; occupancy = active_valid + shadow_full.
- Each cycle, release is evaluated first, then capture against post-release occupancy.
- Release (consume_done & active_valid): if shadow_full, ACTIVE<=SHADOW, shadow_full<=0, active_valid stays 1; else active_valid<=0. consume_done with active_valid=0 is ignored. out keeps its last data when invalid.
- Capture (first|done_in): if active empty, ACTIVE<=in, active_valid<=1. Else if shadow empty, SHADOW<=in, shadow_full<=1. Else drop in, overflow<=1 for one cycle; banks unchanged.
- Simultaneous cases: active full/shadow empty + both events -> ACTIVE<=in, occupancy 1. Both full + both events -> ACTIVE<=old SHADOW, SHADOW<=in, no overflow.
- Stream FSM: IDLE (active_valid=0), STREAM, DRAINED.
  - IDLE -> STREAM on ACTIVE load, idx<=0.
  - STREAM: stream_valid=1. On valid&ready, idx+=LANES. stream_last = (idx == WEIGHT_NO-LANES). Last transfer -> DRAINED, idx<=0.
  - DRAINED: stream_valid=0. Waits for release.
  - Any ACTIVE reload (capture into empty active, or swap) -> STREAM, idx<=0, from any state, including mid-stream.
  - Release leaving active empty -> IDLE.
- stream_data, stream_last are combinational from ACTIVE and registered idx. Data must be stable while valid&!ready.

## Timing
- Reset (async assert, sync-safe deassert): out=0, active_valid=0, occupancy=0, shadow_full=0, stream_valid=0, stream_idx=0, stream_last=0, overflow=0, FSM=IDLE. Reset mid-stream discards both banks.
- Capture latency 1: strobe sampled at edge N; out/active_valid/stream_valid updated after edge N.
- Swap latency 1: consume_done at edge N; new out and idx=0 visible after N.
- Throughput: one beat per cycle while ready=1. Vector streams in WEIGHT_NO/LANES cycles.
- overflow is high exactly the cycle after the dropped strobe.
- Strobes held high for several cycles count as one capture per cycle.

## Test plan
WEIGHT_NO=8, DATA_WIDTH=16, LANES=2 unless noted.
- Reset then first=1 with in=elements 1..8 -> next cycle out=in, active_valid=1, occupancy=1, stream_valid=1, stream_idx=0, stream_data={2,1}.
- ready=1 continuously -> beats {2,1},{4,3},{6,5},{8,7} on consecutive cycles, stream_last only on 4th, then stream_valid=0 (DRAINED).
- Stream active, done_in with vector 11..18 -> occupancy=2, stream unaffected. consume_done -> out=11..18, idx=0, occupancy=1.
- Occupancy 2, third done_in -> overflow pulse 1 cycle, banks unchanged. Same cycle with consume_done -> no overflow, ACTIVE=old shadow, SHADOW=new.
- ready toggled 1,0,0,1 -> stream_data/idx held during stalls; no beat skipped or repeated. LANES=1 run streams 8 single-element beats.
- rst_n low mid-stream at idx=4 -> all outputs zero immediately; post-reset first works normally.
